// File: rtl/wb_rr_mixer.sv
// Round-robin Wishbone channel mixer: NCH slave-side channels share one master port.
// The grant is held for a whole burst, and a stalled transfer is aborted with an error after TMO cycles.
module wb_rr_mixer #(
  parameter int unsigned NCH = 5,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned TMO = 255,
  parameter int unsigned TW  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NCH-1:0]    wbs_cyc_i,
  input  logic [NCH-1:0]    wbs_we_i,
  input  logic [NCH-1:0]    wbs_pref_i,
  input  logic [NCH*AW-1:0] wbs_adr_i,
  input  logic [NCH*DW-1:0] wbs_dat_i,
  output logic [DW-1:0]     wbs_dat_o,
  output logic [NCH-1:0]    wbs_ack_o,
  output logic [NCH-1:0]    wbs_err_o,
  output logic [NCH-1:0]    wbs_rty_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic              wbm_pref_o,
  output logic              wbm_cab_o,
  output logic [3:0]        wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i,
  input  logic [DW-1:0]     wbm_dat_i,
  output logic [NCH-1:0]    gnt_o,
  output logic              tmo_o
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t         r_state, w_state_nx;
  logic [NCH-1:0] r_gnt, w_gnt_nx;
  logic [PW-1:0]  r_ptr, w_ptr_nx;
  logic [TW-1:0]  r_cnt, w_cnt_nx;
  logic           r_tmo;

  logic           w_busy, w_abort, w_own_cyc, w_resp, w_found;
  logic [PW-1:0]  w_idx;
  logic [31:0]    w_sum;

  assign w_busy    = (r_state == S_BUSY);
  assign w_abort   = (r_state == S_ABORT);
  assign w_own_cyc = |(r_gnt & wbs_cyc_i);
  assign w_resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;

  // State, grant, pointer and timeout registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= PW'(NCH - 1);
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
      r_tmo   <= (w_state_nx == S_ABORT);
    end
  end

  // Next-state: rotating-priority search in IDLE, burst lock and stall timeout in BUSY
  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_found    = 1'b0;
    w_idx      = '0;
    w_sum      = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
          w_sum = 32'(r_ptr) + 32'(i);
          if (w_sum >= 32'(NCH)) w_sum = w_sum - 32'(NCH);
          w_idx = PW'(w_sum);
          if (!w_found && wbs_cyc_i[w_idx]) begin
            w_found         = 1'b1;
            w_gnt_nx        = '0;
            w_gnt_nx[w_idx] = 1'b1;
            w_ptr_nx        = w_idx;
            w_state_nx      = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!w_own_cyc) begin
          w_state_nx = S_IDLE;
          w_gnt_nx   = '0;
          w_cnt_nx   = '0;
        end else if (w_resp) begin
          w_cnt_nx = '0;
        end else if (r_cnt == TW'(TMO - 1)) begin
          w_state_nx = S_ABORT;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + TW'(1);
        end
      end
      S_ABORT: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Request payload of the granted channel onto the master port
  always_comb begin
    wbm_we_o   = 1'b0;
    wbm_pref_o = 1'b0;
    wbm_adr_o  = '0;
    wbm_dat_o  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (r_gnt[k]) begin
        wbm_we_o   = wbs_we_i[k];
        wbm_pref_o = wbs_pref_i[k];
        wbm_adr_o  = wbs_adr_i[k*AW +: AW];
        wbm_dat_o  = wbs_dat_i[k*DW +: DW];
      end
    end
  end

  assign wbm_cyc_o = w_busy & w_own_cyc;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_cab_o = 1'b1;
  assign wbm_sel_o = 4'b1111;
  assign wbs_dat_o = wbm_dat_i;

  // Responses reach only the granted channel; an abort reports as an error
  assign wbs_ack_o = w_busy ? (r_gnt & {NCH{wbm_ack_i}}) : '0;
  assign wbs_rty_o = w_busy ? (r_gnt & {NCH{wbm_rty_i}}) : '0;
  assign wbs_err_o = w_abort ? r_gnt : (w_busy ? (r_gnt & {NCH{wbm_err_i}}) : '0);

  assign gnt_o = r_gnt;
  assign tmo_o = r_tmo;

endmodule

// File: tb/tb_wb_rr_mixer.sv
// Scoreboard bench for wb_rr_mixer: a transaction-level model predicts every cycle's outputs,
// and a negedge monitor compares them, alongside directed grant-order and response-routing checks.
module tb_wb_rr_mixer;
  localparam int NCH = 5;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TMO = 255;
  localparam int TW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    wbs_cyc_i, wbs_we_i, wbs_pref_i;
  logic [NCH*AW-1:0] wbs_adr_i;
  logic [NCH*DW-1:0] wbs_dat_i;
  logic [DW-1:0]     wbs_dat_o;
  logic [NCH-1:0]    wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_pref_o, wbm_cab_o;
  logic [3:0]        wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [DW-1:0]     wbm_dat_i;
  logic [NCH-1:0]    gnt_o;
  logic              tmo_o;

  always #5 clk = ~clk;

  wb_rr_mixer #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(TMO), .TW(TW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_pref_i(wbs_pref_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_pref_o(wbm_pref_o), .wbm_cab_o(wbm_cab_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i),
    .gnt_o(gnt_o), .tmo_o(tmo_o)
  );

  // Channel payloads, packed onto the slave-side buses
  logic [AW-1:0] ch_adr [NCH];
  logic [DW-1:0] ch_dat [NCH];
  logic          ch_we  [NCH];
  logic          ch_pref[NCH];
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wbs_adr_i[k*AW +: AW] = ch_adr[k];
      wbs_dat_i[k*DW +: DW] = ch_dat[k];
      wbs_we_i[k]           = ch_we[k];
      wbs_pref_i[k]         = ch_pref[k];
    end
  end

  typedef struct {
    logic [NCH-1:0] gnt;
    logic           cyc;
    logic           we;
    logic           pref;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  dat;
    logic [NCH-1:0] ack, err, rty;
    logic           tmo;
    logic [DW-1:0]  sdat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: owner channel (-1 none), last granted index, stall run length, abort cycle flag
  int m_owner, m_last, m_stall;
  bit m_abort;
  // Channel agents: beats still wanted, burst length, number of re-requests left
  int ch_left[NCH], ch_len[NCH], ch_reps[NCH];
  int resp_mode;
  bit st_err, st_rty, rnd_data;

  // Monitor-side logs
  int ack_cnt[NCH], err_cnt[NCH], rty_cnt[NCH];
  int tmo_cnt;
  int grant_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int k = 0; k < NCH; k++) begin
      ack_cnt[k] = 0; err_cnt[k] = 0; rty_cnt[k] = 0;
    end
    tmo_cnt = 0;
    grant_code = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_owner = -1; m_last = NCH - 1; m_stall = 0; m_abort = 0;
    end else if (m_abort) begin
      m_abort = 0; m_owner = -1;
    end else if (m_owner < 0) begin
      for (int o = 1; o <= NCH; o++) begin
        int c;
        c = (m_last + o) % NCH;
        if (wbs_cyc_i[c]) begin
          m_owner = c; m_last = c;
          break;
        end
      end
    end else if (!wbs_cyc_i[m_owner]) begin
      m_owner = -1; m_stall = 0;
    end else if (wbm_ack_i || wbm_err_i || wbm_rty_i) begin
      m_stall = 0;
      if (ch_left[m_owner] > 0) ch_left[m_owner]--;
    end else begin
      m_stall++;
      if (m_stall == TMO) begin
        m_abort = 1; m_stall = 0;
        ch_left[m_owner] = 0; ch_reps[m_owner] = 0;
      end
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.gnt = '0; e.cyc = 0; e.we = 0; e.pref = 0; e.adr = '0; e.dat = '0;
    e.ack = '0; e.err = '0; e.rty = '0; e.tmo = 0; e.sdat = wbm_dat_i;
    return e;
  endfunction

  // One clock: advance the model at the edge, then drive this cycle's inputs and queue the prediction
  task automatic cycle();
    exp_t e;
    bit   act, busy;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (ch_left[k] == 0 && wbs_cyc_i[k]) wbs_cyc_i[k] = 1'b0;
      else if (ch_left[k] == 0 && ch_reps[k] > 0) begin
        ch_reps[k]--; ch_left[k] = ch_len[k]; wbs_cyc_i[k] = 1'b1;
      end else if (ch_left[k] > 0) wbs_cyc_i[k] = 1'b1;
      if (rnd_data) begin
        ch_adr[k] = $urandom; ch_dat[k] = {$urandom, $urandom};
        ch_we[k] = 1'($urandom_range(0, 1)); ch_pref[k] = 1'($urandom_range(0, 1));
      end
    end
    act  = (m_owner >= 0) && !m_abort;
    busy = act && wbs_cyc_i[m_owner];
    wbm_ack_i = 1'b0; wbm_err_i = st_err; wbm_rty_i = st_rty;
    st_err = 0; st_rty = 0;
    if (resp_mode == 1) wbm_ack_i = busy;
    else if (resp_mode == 2 && busy) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 10) wbm_ack_i = 1'b1;
      else if (r == 10) wbm_err_i = 1'b1;
      else if (r == 11) wbm_rty_i = 1'b1;
    end
    wbm_dat_i = {$urandom, $urandom};
    e = zero_exp();
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.we = ch_we[m_owner]; e.pref = ch_pref[m_owner];
      e.adr = ch_adr[m_owner]; e.dat = ch_dat[m_owner];
    end
    e.cyc = busy;
    if (act && wbm_ack_i) e.ack = e.gnt;
    if (act && wbm_rty_i) e.rty = e.gnt;
    if (m_abort || (act && wbm_err_i)) e.err = e.gnt;
    e.tmo = m_abort;
    q.push_back(e);
  endtask

  task automatic req(input int k, input int len, input int reps);
    ch_len[k] = len; ch_left[k] = len; ch_reps[k] = reps;
  endtask

  function automatic bit quiet();
    bit b;
    b = (m_owner < 0) && !m_abort && (wbs_cyc_i == '0);
    for (int k = 0; k < NCH; k++) if (ch_left[k] != 0 || ch_reps[k] != 0) b = 0;
    return b;
  endfunction

  task automatic run_until_quiet(input string name, input int maxc);
    int n;
    n = 0;
    while (!quiet() && n < maxc) begin cycle(); n++; end
    cycle();
    cycle();
    if (!quiet()) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", name, maxc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NCH; k++) begin ch_left[k] = 0; ch_reps[k] = 0; end
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction and log events
  initial begin : mon
    exp_t e;
    logic [NCH-1:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (gnt_o !== e.gnt || wbm_cyc_o !== e.cyc || wbm_stb_o !== e.cyc ||
            wbs_ack_o !== e.ack || wbs_err_o !== e.err || wbs_rty_o !== e.rty ||
            tmo_o !== e.tmo || wbs_dat_o !== e.sdat || wbm_cab_o !== 1'b1 ||
            wbm_sel_o !== 4'hF || (e.gnt != '0 && (wbm_adr_o !== e.adr ||
            wbm_dat_o !== e.dat || wbm_we_o !== e.we || wbm_pref_o !== e.pref))) begin
          failures++;
          $display("FAIL cycle t=%0t gnt=%b/%b cyc=%b/%b ack=%b/%b err=%b/%b rty=%b/%b tmo=%b/%b adr=%h/%h we=%b/%b (actual/required)",
                   $time, gnt_o, e.gnt, wbm_cyc_o, e.cyc, wbs_ack_o, e.ack, wbs_err_o, e.err,
                   wbs_rty_o, e.rty, tmo_o, e.tmo, wbm_adr_o, e.adr, wbm_we_o, e.we);
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (wbs_ack_o[k]) ack_cnt[k]++;
        if (wbs_err_o[k]) err_cnt[k]++;
        if (wbs_rty_o[k]) rty_cnt[k]++;
        if (gnt_o[k] && prev_gnt == '0) grant_code = (grant_code << 4) | (k + 1);
      end
      if (tmo_o) tmo_cnt++;
      prev_gnt = gnt_o;
    end
  end

  initial begin
    rst_n = 1'b0; wbs_cyc_i = '0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_dat_i = '0;
    resp_mode = 1; st_err = 0; st_rty = 0; rnd_data = 0;
    m_owner = -1; m_last = NCH - 1; m_stall = 0; m_abort = 0;
    for (int k = 0; k < NCH; k++) begin
      ch_adr[k] = 32'h2000_0000 + 32'(k * 'h100); ch_dat[k] = {32'(k), 32'hA5A5_0000 + 32'(k)};
      ch_we[k] = 1'(k % 2); ch_pref[k] = 1'((k / 2) % 2);
      ch_left[k] = 0; ch_len[k] = 0; ch_reps[k] = 0;
    end
    clear_logs();

    // Reset state
    cycle(); cycle();
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_cyc", 64'(wbm_cyc_o), 64'h0);
    check("rst_tmo", 64'(tmo_o), 64'h0);
    rst_n = 1'b1;
    cycle();

    // Channel 2 alone, four acked beats
    clear_logs();
    ch_adr[2] = 32'h1000_0040;
    req(2, 4, 0);
    cycle();
    cycle();
    check("t1_gnt_latency", 64'(gnt_o), 64'h04);
    check("t1_adr", 64'(wbm_adr_o), 64'h1000_0040);
    run_until_quiet("t1", 40);
    check("t1_grants", 64'(grant_code), 64'h3);
    check("t1_acks", 64'(ack_cnt[2]), 64'd4);
    check("t1_idle_gnt", 64'(gnt_o), 64'h0);

    // Channels 0 and 3 single beats with re-requests, from reset
    do_reset();
    clear_logs();
    req(0, 1, 1); req(3, 1, 1);
    run_until_quiet("t2", 60);
    check("t2_order", 64'(grant_code), 64'h1414);

    // Channel 1 burst of 16 with 0 and 4 waiting
    clear_logs();
    req(1, 16, 0);
    cycle();
    req(0, 2, 0); req(4, 2, 0);
    run_until_quiet("t3", 80);
    check("t3_order", 64'(grant_code), 64'h251);
    check("t3_acks1", 64'(ack_cnt[1]), 64'd16);

    // Channel 3 stalls until the timeout; channel 4 waits behind it
    clear_logs();
    resp_mode = 0;
    req(3, 1, 0);
    cycle();
    req(4, 1, 0);
    for (int n = 0; n < 300 && tmo_cnt == 0; n++) cycle();
    resp_mode = 1;
    run_until_quiet("t4", 40);
    check("t4_tmo_pulses", 64'(tmo_cnt), 64'd1);
    check("t4_err3", 64'(err_cnt[3]), 64'd1);
    check("t4_err4", 64'(err_cnt[4]), 64'd0);
    check("t4_order", 64'(grant_code), 64'h45);

    // Bus error and retry during a channel 0 grant with channel 2 waiting
    clear_logs();
    resp_mode = 0;
    req(0, 3, 0);
    cycle();
    req(2, 1, 0);
    for (int n = 0; n < 20 && m_owner != 0; n++) cycle();
    st_err = 1; cycle();
    st_rty = 1; cycle();
    resp_mode = 1;
    run_until_quiet("t5", 40);
    check("t5_err0", 64'(err_cnt[0]), 64'd1);
    check("t5_rty0", 64'(rty_cnt[0]), 64'd1);
    check("t5_err_others", 64'(err_cnt[1] + err_cnt[2] + err_cnt[3] + err_cnt[4]), 64'd0);
    check("t5_rty_others", 64'(rty_cnt[1] + rty_cnt[2] + rty_cnt[3] + rty_cnt[4]), 64'd0);

    // Randomized traffic against the model
    rnd_data = 1; resp_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NCH; k++)
        if (ch_left[k] == 0 && ch_reps[k] == 0 && !wbs_cyc_i[k] && $urandom_range(0, 7) == 0)
          req(k, $urandom_range(1, 6), $urandom_range(0, 1));
      cycle();
    end
    resp_mode = 1;
    run_until_quiet("rand", 400);
    rnd_data = 0;

    // Asynchronous reset in the middle of a channel 2 burst
    clear_logs();
    req(2, 100, 0);
    for (int n = 0; n < 20 && m_owner != 2; n++) cycle();
    cycle(); cycle();
    #2;
    rst_n = 1'b0;
    wbm_ack_i = 1'b1;
    #1;
    check("t7_gnt", 64'(gnt_o), 64'h0);
    check("t7_cyc", 64'(wbm_cyc_o), 64'h0);
    check("t7_ack", 64'(wbs_ack_o), 64'h0);
    q[$] = zero_exp();
    for (int k = 0; k < NCH; k++) ch_left[k] = 0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    clear_logs();
    req(0, 1, 0); req(3, 1, 0);
    run_until_quiet("t7", 40);
    check("t7_order", 64'(grant_code), 64'h14);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_rr_mixer.md
Name: wb_rr_mixer

Overview:
- Parametrised successor to the fixed 5-channel Wishbone channel mixer in the DMA datapath.
- Multiplexes NCH Wishbone slave-side channels onto one master port toward the host bus.
- Has its own round-robin arbiter and holds the grant for a whole burst.
- Routes ack/err/rty only to the granted channel, and aborts stalled transfers with a bus timeout.

Parameters:
- NCH, 5, number of requesting channels (2..8).
- AW, 32, address width.
- DW, 64, data width (low and high 32-bit lanes combined).
- TMO, 255, cycles without ack/err/rty in BUSY before abort (1..65535).
- TW, 16, timeout counter width; must satisfy 2^TW > TMO.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-low reset
- wbs_cyc_i  in  NCH  per-channel cycle request
- wbs_we_i  in  NCH  per-channel write enable
- wbs_pref_i  in  NCH  per-channel prefetch hint
- wbs_adr_i  in  NCH*AW  channel addresses, channel k at [k*AW +: AW]
- wbs_dat_i  in  NCH*DW  channel write data, channel k at [k*DW +: DW]
- wbs_dat_o  out  DW  read data, broadcast to all channels
- wbs_ack_o  out  NCH  ack to granted channel only
- wbs_err_o  out  NCH  error to granted channel only (bus error or timeout)
- wbs_rty_o  out  NCH  retry to granted channel only
- wbm_cyc_o  out  1  master cycle
- wbm_stb_o  out  1  master strobe, equals wbm_cyc_o
- wbm_we_o  out  1  master write enable
- wbm_pref_o  out  1  master prefetch hint
- wbm_cab_o  out  1  constant 1
- wbm_sel_o  out  4  constant 4'b1111
- wbm_adr_o  out  AW  master address
- wbm_dat_o  out  DW  master write data
- wbm_ack_i  in  1  master ack
- wbm_err_i  in  1  master error
- wbm_rty_i  in  1  master retry
- wbm_dat_i  in  DW  master read data
- gnt_o  out  NCH  registered one-hot grant (status / debug)
- tmo_o  out  1  one-cycle pulse on each timeout abort

Behaviour:
Reset:
- wb_rst_i low clears state to IDLE, gnt_o to 0, rr pointer to NCH-1 and timeout counter to 0.
- Outputs derived from grant are therefore 0 during reset.
- Reset is asynchronous; release is sampled on wb_clk_i.

State machine (IDLE, BUSY, ABORT):
- IDLE:
  - Drives wbm_cyc_o=0.
  - If any wbs_cyc_i bit is set, grant the first set bit searching upward (with wrap) from pointer+1.
  - gnt_o is registered, so the state becomes BUSY next cycle (1 cycle request-to-cyc latency).
  - The rr pointer is updated to the granted index.
- BUSY:
  - wbm_cyc_o = |(gnt_o & wbs_cyc_i).
  - wbm_we_o, wbm_pref_o, wbm_adr_o and wbm_dat_o are muxed combinationally from the granted channel.
  - wbs_ack_o = gnt_o & {NCH{wbm_ack_i}}; err and rty are routed the same way.
  - The grant is held while the granted channel keeps wbs_cyc_i high, regardless of other requests (burst lock).
  - When the granted wbs_cyc_i is low at a clock edge: gnt_o clears and the state returns to IDLE. There is one dead cycle before the next grant.
- Timeout counter:
  - Increments every BUSY cycle with wbm_cyc_o=1 and none of ack/err/rty.
  - Clears on any of ack/err/rty, and on leaving BUSY.
  - On reaching TMO, the next state is ABORT.
- ABORT (one cycle):
  - wbm_cyc_o=0.
  - wbs_err_o asserted to the granted channel only.
  - tmo_o=1.
  - Next state IDLE; gnt_o clears. The pointer stays at the aborted channel, so other requesters take priority.

Boundary rules:
- All NCH request at once: grants cycle 0,1,...,NCH-1,0 across successive bursts.
- Requests that are not granted receive no ack, err or rty.
- Ack in the same cycle the counter would hit TMO: the ack wins and the counter clears.
- Granted cyc drops in the same cycle as ack: ack is delivered, then the state goes to IDLE.
- Reset asserted mid-burst: wbm_cyc_o drops immediately (asynchronously) and no ack is forwarded.
- wbs_dat_o = wbm_dat_i at all times.

Test Plan:
- Channel 2 only asserts cyc, adr=0x1000_0040, for 4 acked beats → gnt_o=5'b00100 one cycle after request; wbm_adr_o=0x1000_0040; wbs_ack_o[2] on each of 4 beats; IDLE after cyc drops.
- Channels 0 and 3 assert cyc simultaneously after reset, each doing 1 beat, both re-requesting → grant order 0,3,0,3; one dead cycle between grants.
- Channel 1 runs a 16-beat burst while channels 0 and 4 request → grant held on 1 for all 16 beats; channel 4 is granted next, then 0.
- Channel 3 granted and no ack for TMO=255 cycles → ABORT: wbs_err_o=5'b01000 for one cycle, tmo_o pulses, wbm_cyc_o low; channel 4 (also requesting) granted next.
- wbm_err_i and wbm_rty_i pulsed during channel 0 grant → only wbs_err_o[0] and wbs_rty_o[0] assert; the other channels stay 0.
- wb_rst_i driven low mid-burst on channel 2 → wbm_cyc_o, gnt_o and wbs_ack_o go to 0 immediately; after release, a request from channel 0 is granted first.
